// File: rtl/othello_pkg.sv
// Shared encodings for the Othello move pipeline: cell values, directions,
// scanner FSM states and board-address steps for an 8x8 row-major board.
package othello_pkg;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_e;

  typedef enum logic [3:0] {
    IDLE, CHK_A, CHK_R, DIR_INIT, PROBE_A, PROBE_R,
    LOAD, FLIP, WAIT_FLIP, NEXT_DIR, DONE
  } state_e;

  // Five-bit two's-complement address deltas, row*8+col
  localparam logic [4:0] STEP_N  = 5'b11000;
  localparam logic [4:0] STEP_NE = 5'b11001;
  localparam logic [4:0] STEP_E  = 5'b00001;
  localparam logic [4:0] STEP_SE = 5'b01001;
  localparam logic [4:0] STEP_S  = 5'b01000;
  localparam logic [4:0] STEP_SW = 5'b00111;
  localparam logic [4:0] STEP_W  = 5'b11111;
  localparam logic [4:0] STEP_NW = 5'b10111;
endpackage

// File: rtl/dir_lut.sv
// Direction decode: dir index to flipper address step and signed 2-bit
// row/col deltas (11 = -1, 00 = 0, 01 = +1).
module dir_lut
  import othello_pkg::*;
(
  input  logic [2:0] dir,
  output logic [4:0] step,
  output logic [1:0] drow,
  output logic [1:0] dcol
);
  always_comb begin
    step = STEP_N;
    drow = 2'b11;
    dcol = 2'b00;
    case (dir_e'(dir))
      DIR_N:  begin step = STEP_N;  drow = 2'b11; dcol = 2'b00; end
      DIR_NE: begin step = STEP_NE; drow = 2'b11; dcol = 2'b01; end
      DIR_E:  begin step = STEP_E;  drow = 2'b00; dcol = 2'b01; end
      DIR_SE: begin step = STEP_SE; drow = 2'b01; dcol = 2'b01; end
      DIR_S:  begin step = STEP_S;  drow = 2'b01; dcol = 2'b00; end
      DIR_SW: begin step = STEP_SW; drow = 2'b01; dcol = 2'b11; end
      DIR_W:  begin step = STEP_W;  drow = 2'b00; dcol = 2'b11; end
      DIR_NW: begin step = STEP_NW; drow = 2'b11; dcol = 2'b11; end
    endcase
  end
endmodule

// File: rtl/move_scanner.sv
// Othello move validator: probes eight directions from the target square and
// dispatches each bracketed run to the flipper. MOVE_SCAN_DRY_RUN_EN skips dispatch.
module move_scanner
  import othello_pkg::*;
#(
  parameter int BOARD_W = 8
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] move_addr,
  input  logic       player,
  input  logic [1:0] data_in,
  input  logic       flip_done,
  output logic [6:0] addr_out,
  output logic       mem_req,
  output logic [6:0] s_addr_out,
  output logic [4:0] step_o,
  output logic       ld_o,
  output logic       start_flip,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [4:0] flip_count
);
  localparam logic [3:0] LIM = 4'(BOARD_W);

  state_e     state, state_next;
  logic [5:0] move_q;
  logic       player_q;
  logic [2:0] dir, row, col;
  logic [4:0] run, step_q, count_q, lut_step;
  logic [6:0] addr_q;
  logic       valid_q;
  logic [1:0] drow, dcol;
  logic [3:0] nrow, ncol;
  logic       in_bounds, is_own, is_opp, is_empty;

  dir_lut u_lut (.dir(dir), .step(lut_step), .drow(drow), .dcol(dcol));

  // Edge detection uses the tracked row/col, so a -1 or 8 lands at >= LIM
  assign nrow      = {1'b0, row} + {{2{drow[1]}}, drow};
  assign ncol      = {1'b0, col} + {{2{dcol[1]}}, dcol};
  assign in_bounds = (nrow < LIM) && (ncol < LIM);
  assign is_own    = data_in == (player_q ? WHITE : BLACK);
  assign is_opp    = data_in == (player_q ? BLACK : WHITE);
  assign is_empty  = (data_in == EMPTY) || (data_in == 2'b11);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = CHK_A;
      CHK_A:     state_next = CHK_R;
      CHK_R:     state_next = is_empty ? DIR_INIT : DONE;
      DIR_INIT:  state_next = PROBE_A;
      PROBE_A:   state_next = in_bounds ? PROBE_R : NEXT_DIR;
      PROBE_R: begin
        if (is_opp)                     state_next = PROBE_A;
`ifdef MOVE_SCAN_DRY_RUN_EN
        else                            state_next = NEXT_DIR;
`else
        else if (is_own && run != 5'd0) state_next = LOAD;
        else                            state_next = NEXT_DIR;
`endif
      end
      LOAD:      state_next = FLIP;
      FLIP:      state_next = WAIT_FLIP;
      WAIT_FLIP: if (flip_done) state_next = NEXT_DIR;
      NEXT_DIR:  state_next = (dir == 3'd7) ? DONE : DIR_INIT;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      move_q   <= '0;
      player_q <= 1'b0;
      dir      <= '0;
      row      <= '0;
      col      <= '0;
      run      <= '0;
      step_q   <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          move_q   <= move_addr;
          player_q <= player;
          addr_q   <= {1'b0, move_addr};
          valid_q  <= 1'b0;
          count_q  <= '0;
        end
        CHK_R:    dir <= '0;
        DIR_INIT: begin
          row <= move_q[5:3];
          col <= move_q[2:0];
          run <= '0;
        end
        PROBE_A: if (in_bounds) begin
          row    <= nrow[2:0];
          col    <= ncol[2:0];
          addr_q <= {1'b0, nrow[2:0], ncol[2:0]};
        end
        PROBE_R: begin
          if (is_opp) run <= run + 5'd1;
          else if (is_own && run != 5'd0) begin
            step_q <= lut_step;
`ifdef MOVE_SCAN_DRY_RUN_EN
            valid_q <= 1'b1;
            count_q <= count_q + run;
`endif
          end
        end
        FLIP: begin
          valid_q <= 1'b1;
          count_q <= count_q + run;
        end
        NEXT_DIR: dir <= dir + 3'd1;
        default: ;
      endcase
    end
  end

  // Probe address is presented combinationally so data_in lines up with PROBE_R
  assign addr_out   = (state == PROBE_A && in_bounds) ? {1'b0, nrow[2:0], ncol[2:0]} : addr_q;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign mem_req    = busy && state != FLIP && state != WAIT_FLIP;
  assign s_addr_out = {1'b0, move_q};
  assign step_o     = step_q;
  assign valid      = valid_q;
  assign flip_count = count_q;
`ifdef MOVE_SCAN_DRY_RUN_EN
  assign ld_o       = 1'b0;
  assign start_flip = 1'b0;
`else
  assign ld_o       = state == LOAD;
  assign start_flip = state == FLIP;
`endif
endmodule

// File: tb/tb_move_scanner.sv
// Bench for move_scanner: board memory and flipper models, hand vectors,
// reset/ignore sequences and randomized boards against a direction-walk model.
module tb_move_scanner;
`ifdef MOVE_SCAN_DRY_RUN_EN
  localparam bit DRY = 1'b1;
`else
  localparam bit DRY = 1'b0;
`endif

  logic       clock = 1'b0, reset = 1'b0, start = 1'b0, player = 1'b0;
  logic [5:0] move_addr = '0;
  logic [1:0] data_in;
  logic       flip_done, fl_done = 1'b0, inj_done = 1'b0;
  logic [6:0] addr_out, s_addr_out;
  logic [4:0] step_o, flip_count;
  logic       mem_req, ld_o, start_flip, busy, done, valid;
  logic [29:0] outs;

  int total = 0, bad = 0;
  int flip_lat = 2, fcnt = 0;
  logic [1:0] board [64];
  logic [4:0] ld_steps [$];
  logic [6:0] ld_saddr [$];
  logic [6:0] addrs [$];
  logic       prev_ld = 1'b0;

  logic       m_valid;
  int         m_cnt, m_cycles;
  logic [4:0] m_steps [$];

  typedef struct {
    logic [127:0] brd;
    logic         ply;
    logic [5:0]   mv;
    logic         exp_valid;
    logic [4:0]   exp_cnt;
    int           exp_nld;
    logic [4:0]   exp_s0;
    logic [4:0]   exp_s1;
  } vec_t;
  vec_t vecs [5];

  always #5 clock = ~clock;

  move_scanner #(.BOARD_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .move_addr(move_addr),
    .player(player), .data_in(data_in), .flip_done(flip_done),
    .addr_out(addr_out), .mem_req(mem_req), .s_addr_out(s_addr_out),
    .step_o(step_o), .ld_o(ld_o), .start_flip(start_flip), .busy(busy),
    .done(done), .valid(valid), .flip_count(flip_count)
  );

  assign outs = {addr_out, mem_req, s_addr_out, step_o, ld_o, start_flip, busy, done, valid, flip_count};
  assign flip_done = fl_done | inj_done;

  // Board read port: one cycle latency
  always @(posedge clock) data_in <= board[addr_out[5:0]];

  // Flipper: done pulse flip_lat+1 cycles into WAIT_FLIP
  always @(posedge clock) begin
    fl_done <= 1'b0;
    if (start_flip) fcnt <= flip_lat;
    else if (fcnt != 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) fl_done <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (ld_o) begin
      ld_steps.push_back(step_o);
      ld_saddr.push_back(s_addr_out);
      chk("ld_launch_overlap", start_flip, 0);
    end
    if (start_flip) chk("ld_before_launch", prev_ld, 1);
    if (busy && !mem_req && ld_steps.size() != 0)
      chk("step_hold", step_o, ld_steps[ld_steps.size()-1]);
    if (busy) addrs.push_back(addr_out);
    prev_ld <= ld_o;
  end

  function automatic logic [127:0] put(input logic [127:0] b, input int idx, input logic [1:0] v);
    b[2*idx +: 2] = v;
    return b;
  endfunction

  task automatic load_board(input logic [127:0] b);
    for (int i = 0; i < 64; i++) board[i] = b[2*i +: 2];
  endtask

  // Walk each direction on the board array; count cost cycles along the way
  task automatic model(input logic ply, input logic [5:0] mv);
    int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int own, opp, r, c, n;
    own = ply ? 2 : 1;
    opp = ply ? 1 : 2;
    m_valid = 1'b0; m_cnt = 0; m_cycles = 3;
    m_steps.delete();
    if (board[mv] == 2'd1 || board[mv] == 2'd2) return;
    for (int d = 0; d < 8; d++) begin
      m_cycles += 2;
      r = int'(mv) / 8; c = int'(mv) % 8; n = 0;
      while (1) begin
        r += dr[d]; c += dc[d];
        if (r < 0 || r > 7 || c < 0 || c > 7) begin m_cycles += 1; break; end
        m_cycles += 2;
        if (board[r*8+c] == 2'(opp)) n++;
        else begin
          if (board[r*8+c] == 2'(own) && n > 0) begin
            m_valid = 1'b1;
            m_cnt += n;
            if (!DRY) begin
              m_steps.push_back(5'(dr[d]*8 + dc[d]));
              m_cycles += 2 + flip_lat + 1;
            end
          end
          break;
        end
      end
    end
  endtask

  task automatic run_move(input logic ply, input logic [5:0] mv,
                          output int lat, output logic gv, output logic [4:0] gc);
    logic ok;
    @(posedge clock); #1;
    ld_steps.delete(); ld_saddr.delete(); addrs.delete();
    start = 1'b1; player = ply; move_addr = mv;
    @(posedge clock); #1 start = 1'b0;
    lat = 0; ok = 1'b0; gv = 1'b0; gc = '0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clock);
      if (done) begin lat = n; ok = 1'b1; gv = valid; gc = flip_count; break; end
      @(posedge clock);
    end
    if (!ok) chk("done_timeout", ok, 1);
  endtask

  task automatic check_result(input string tag, input logic [5:0] mv, input int lat,
                              input logic gv, input logic [4:0] gc);
    chk({tag, "_valid"}, gv, m_valid);
    chk({tag, "_count"}, gc, m_cnt);
    chk({tag, "_latency"}, lat, m_cycles);
    chk({tag, "_dispatches"}, ld_steps.size(), m_steps.size());
    for (int k = 0; k < m_steps.size() && k < ld_steps.size(); k++) begin
      chk({tag, "_step"}, ld_steps[k], m_steps[k]);
      chk({tag, "_saddr"}, ld_saddr[k], {1'b0, mv});
    end
  endtask

  initial begin
    logic [127:0] b_open, b_wrap, b_multi;
    int lat, act, nb;
    logic gv;
    logic [4:0] gc;

    b_open = '0;
    b_open = put(b_open, 27, 2'b10); b_open = put(b_open, 28, 2'b01);
    b_open = put(b_open, 35, 2'b01); b_open = put(b_open, 36, 2'b10);
    b_wrap = '0;
    b_wrap = put(b_wrap, 8, 2'b10); b_wrap = put(b_wrap, 9, 2'b01);
    b_multi = '0;
    b_multi = put(b_multi, 19, 2'b10); b_multi = put(b_multi, 11, 2'b10);
    b_multi = put(b_multi, 3, 2'b01);  b_multi = put(b_multi, 26, 2'b10);
    b_multi = put(b_multi, 25, 2'b01);

    vecs[0] = '{b_open,  1'b0, 6'd19, 1'b1, 5'd1, 1, 5'b01000, 5'b00000};
    vecs[1] = '{b_open,  1'b0, 6'd20, 1'b0, 5'd0, 0, 5'b00000, 5'b00000};
    vecs[2] = '{b_open,  1'b0, 6'd27, 1'b0, 5'd0, 0, 5'b00000, 5'b00000};
    vecs[3] = '{b_wrap,  1'b0, 6'd7,  1'b0, 5'd0, 0, 5'b00000, 5'b00000};
    vecs[4] = '{b_multi, 1'b0, 6'd27, 1'b1, 5'd3, 2, 5'b11000, 5'b11111};

    load_board('0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", outs, 0);
    @(posedge clock); #1 reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      load_board(vecs[i].brd);
      flip_lat = 2;
      model(vecs[i].ply, vecs[i].mv);
      run_move(vecs[i].ply, vecs[i].mv, lat, gv, gc);
      chk($sformatf("v%0d_valid", i), gv, vecs[i].exp_valid);
      chk($sformatf("v%0d_count", i), gc, vecs[i].exp_cnt);
      chk($sformatf("v%0d_dispatches", i), ld_steps.size(), DRY ? 0 : vecs[i].exp_nld);
      chk($sformatf("v%0d_latency", i), lat, m_cycles);
      if (ld_steps.size() > 0) begin
        chk($sformatf("v%0d_step0", i), ld_steps[0], vecs[i].exp_s0);
        chk($sformatf("v%0d_saddr0", i), ld_saddr[0], {1'b0, vecs[i].mv});
      end
      if (ld_steps.size() > 1) chk($sformatf("v%0d_step1", i), ld_steps[1], vecs[i].exp_s1);
      if (i == 2) begin
        chk("occupied_latency", lat, 3);
        nb = 0;
        foreach (addrs[k]) if (addrs[k] != 7'd27) nb++;
        chk("occupied_addr_only_27", nb, 0);
      end
      if (i == 3) begin
        nb = 0;
        foreach (addrs[k]) if (addrs[k] == 7'd8) nb++;
        chk("wrap_addr8_seen", nb, 0);
      end
      @(negedge clock);
      chk($sformatf("v%0d_valid_held", i), valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_count_held", i), flip_count, vecs[i].exp_cnt);
    end

    // start during busy is ignored and the latched square is kept
    load_board(b_open);
    @(posedge clock); #1 start = 1'b1; player = 1'b0; move_addr = 6'd27;
    @(posedge clock); #1 move_addr = 6'd19;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    chk("busy_ign_addr", addr_out, 27);
    @(negedge clock);
    chk("busy_ign_done", done, 1);
    chk("busy_ign_valid", valid, 0);
    @(negedge clock);
    chk("busy_ign_idle", busy, 0);

    // reset while waiting on the flipper
    load_board(b_multi);
    flip_lat = 10;
    @(posedge clock); #1 start = 1'b1; player = 1'b0; move_addr = 6'd27;
    @(posedge clock); #1 start = 1'b0;
    nb = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (start_flip) begin nb = 1; break; end
    end
    chk("rst_reached_flip", nb, DRY ? 0 : 1);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    if (!DRY) chk("rst_in_wait_memreq", mem_req, 0);
    @(negedge clock);
    chk("rst_abort_outputs", outs, 0);
    @(posedge clock); #1 reset = 1'b1;
    act = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1 inj_done = (n == 3);
      @(negedge clock);
      if (busy | ld_o | start_flip | done | mem_req) act++;
    end
    inj_done = 1'b0;
    chk("rst_quiet_after", act, 0);

    // randomized boards against the model
    for (int t = 0; t < 40; t++) begin
      logic [5:0] mv;
      logic ply;
      for (int i = 0; i < 64; i++) begin
        int v;
        v = $urandom_range(0, 5);
        board[i] = (v > 3) ? 2'b00 : 2'(v);
      end
      mv = 6'($urandom_range(0, 63));
      ply = 1'($urandom_range(0, 1));
      if (t % 2 == 0) board[mv] = 2'b00;
      flip_lat = $urandom_range(1, 4);
      model(ply, mv);
      run_move(ply, mv, lat, gv, gc);
      check_result($sformatf("rnd%0d", t), mv, lat, gv, gc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
